// File: rtl/pc_next_unit.sv
// pc_next_unit -- fetch PC register with registered branch/jump redirect.
//
// Holds the fetch PC and advances it by 4 every non-stalled cycle. A control
// request from decode (taken branch, J/JAL, JR/JALR) has its target computed
// and latched on the accepting edge while the PC still steps over the delay
// slot. The following non-stalled edge loads the latched target and pulses
// redir. Simultaneous requests, or a request arriving while a redirect is
// pending, set the sticky redir_err flag.
//
// Optional build macro: PC_RAS_EN adds a circular return-address stack of
// RAS_DEPTH entries (pushed by linking jumps, popped by JR without link).
// Without it, ras_top reads 0 and ras_empty reads 1.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   stall      freeze all state; requests are ignored while high
//   req_pc     address of the requesting control instruction
//   br_valid   conditional-branch request, qualified by br_taken
//   br_taken   branch condition result
//   br_offset  signed word offset of the branch
//   j_valid    J/JAL request
//   j_index    26-bit jump index
//   jr_valid   JR/JALR request
//   jr_target  register target of JR/JALR
//   link       request is JAL/JALR
//   pc_out     current fetch PC (registered)
//   redir      one-cycle pulse: pc_out was just loaded from a target
//   redir_err  sticky protocol-error flag, cleared only by rst
//   ras_top    predicted return address
//   ras_empty  return-address stack is empty
module pc_next_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'hBFC0_0000),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] req_pc,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [15:0]      br_offset,
    input  logic             j_valid,
    input  logic [25:0]      j_index,
    input  logic             jr_valid,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             link,
    output logic [WIDTH-1:0] pc_out,
    output logic             redir,
    output logic             redir_err,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty
);

    typedef enum logic {ST_SEQ, ST_PEND} state_t;

    // Bits of p4 that survive into a J/JAL target (everything above bit 27).
    localparam logic [WIDTH-1:0] J_KEEP_MASK = ~WIDTH'(28'hFFF_FFFF);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] p4, br_tgt, j_tgt, jr_tgt, win_tgt;
    logic             br_req, any_req, multi_req;
    logic             accept, apply, err_set;
    logic [1:0]       addr_unused;

    // ------------------------------------------------------------------
    // Target arithmetic, all modulo 2^WIDTH.
    // ------------------------------------------------------------------
    assign p4     = req_pc + WIDTH'(4);
    assign br_tgt = p4 + {{(WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
    assign j_tgt  = (p4 & J_KEEP_MASK) | WIDTH'({j_index, 2'b00});
    assign jr_tgt = {jr_target[WIDTH-1:2], 2'b00};

    // Word alignment drops the low register bits.
    assign addr_unused = jr_target[1:0];

    assign br_req  = br_valid & br_taken;
    assign any_req = br_req | j_valid | jr_valid;
    // Decode may only raise one request class per cycle; any overlap of the
    // raw valids is a protocol error even though a winner is still chosen.
    assign multi_req = (jr_valid & j_valid) | (jr_valid & br_valid) | (j_valid & br_valid);

    always_comb begin
        if (jr_valid)     win_tgt = jr_tgt;
        else if (j_valid) win_tgt = j_tgt;
        else              win_tgt = br_tgt;
    end

    // ------------------------------------------------------------------
    // Redirect state machine: next state and strobes.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        apply   = 1'b0;
        err_set = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_SEQ: begin
                    if (any_req) begin
                        accept  = 1'b1;
                        err_set = multi_req;
                        state_d = ST_PEND;
                    end
                end
                ST_PEND: begin
                    apply   = 1'b1;
                    err_set = any_req;
                    state_d = ST_SEQ;
                end
                default: state_d = ST_SEQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEQ;
            pc_out    <= RESET_VECTOR;
            tgt_q     <= '0;
            redir     <= 1'b0;
            redir_err <= 1'b0;
        end else begin
            state_q <= state_d;
            redir   <= apply;
            if (!stall) begin
                pc_out <= apply ? tgt_q : pc_out + WIDTH'(4);
            end
            if (accept) begin
                tgt_q <= win_tgt;
            end
            if (err_set) begin
                redir_err <= 1'b1;
            end
        end
    end

`ifdef PC_RAS_EN
    // ------------------------------------------------------------------
    // Circular return-address stack. ras_ptr is the next write slot, so the
    // top entry sits at ras_ptr-1; the count saturates so an overflowing
    // push simply overwrites the oldest entry.
    // ------------------------------------------------------------------
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;
    logic             ras_push, ras_pop;

    assign ras_push  = accept & link & (j_valid | jr_valid);
    assign ras_pop   = accept & jr_valid & ~link & (ras_cnt != '0);
    assign ras_empty = (ras_cnt == '0);
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr - PTR_W'(1)];

    // NOTE: the stack storage has no reset; entries are only visible once the
    // count covers them, so stale contents can never reach ras_top.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= req_pc + WIDTH'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_cnt != (PTR_W+1)'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + (PTR_W+1)'(1);
            end
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_W'(1);
            ras_cnt <= ras_cnt - (PTR_W+1)'(1);
        end
    end
`else
    logic ras_unused;

    assign ras_unused = link;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit. Expected PC/redir values and expected
// return-stack values are pushed onto scoreboard queues as stimulus is driven
// and popped after the clock edge that should produce them.
module tb_pc_next_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] pc;
        logic         redir;
    } pc_exp_t;

    typedef struct {
        logic [W-1:0] top;
        logic         empty;
    } ras_exp_t;

    logic         clk = 1'b0;
    logic         rst, stall;
    logic [W-1:0] req_pc, jr_target;
    logic         br_valid, br_taken, j_valid, jr_valid, link;
    logic [15:0]  br_offset;
    logic [25:0]  j_index;
    logic [W-1:0] pc_out, ras_top;
    logic         redir, redir_err, ras_empty;

    int errors = 0;
    int checks = 0;

    pc_exp_t  sb[$];
    ras_exp_t rsb[$];
    pc_exp_t  e;
    ras_exp_t re;

    pc_next_unit #(.WIDTH(W), .RESET_VECTOR(32'hBFC0_0000), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_pc    (req_pc),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .j_valid   (j_valid),
        .j_index   (j_index),
        .jr_valid  (jr_valid),
        .jr_target (jr_target),
        .link      (link),
        .pc_out    (pc_out),
        .redir     (redir),
        .redir_err (redir_err),
        .ras_top   (ras_top),
        .ras_empty (ras_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish before limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_pc    = '0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_offset = '0;
        j_valid   = 1'b0;
        j_index   = '0;
        jr_valid  = 1'b0;
        jr_target = '0;
        link      = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stall = 1'b0;
        clear_reqs();
        tick();
        tick();
        checks++;
        if (pc_out !== 32'hBFC0_0000 || redir !== 1'b0 || redir_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc_out=%h redir=%b err=%b, want BFC00000 0 0", pc_out, redir, redir_err);
        end
        checks++;
        if (ras_top !== '0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_ras: ras_top=%h empty=%b, want 0 1", ras_top, ras_empty);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back('{32'hBFC0_0000 + 32'(4*i), 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL seq_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
    endtask

    // pc_out = BFC00010 on entry.
    task automatic test_branch();
        req_pc = 32'hBFC0_000C; br_valid = 1'b1; br_taken = 1'b1; br_offset = 16'hFFFC;
        sb.push_back('{32'hBFC0_0014, 1'b0});
        tick();
        clear_reqs();
        sb.push_back('{32'hBFC0_0000, 1'b1});
        sb.push_back('{32'hBFC0_0004, 1'b0});
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL branch_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
        checks++;
        if (redir_err !== 1'b0) begin
            errors++;
            $display("FAIL branch_err: redir_err=%b, want 0", redir_err);
        end
    endtask

    // pc_out = BFC00004 on entry.
    task automatic test_not_taken();
        req_pc = 32'hBFC0_0000; br_valid = 1'b1; br_taken = 1'b0; br_offset = 16'h0100;
        sb.push_back('{32'hBFC0_0008, 1'b0});
        tick();
        clear_reqs();
        sb.push_back('{32'hBFC0_000C, 1'b0});
        sb.push_back('{32'hBFC0_0010, 1'b0});
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL not_taken_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
    endtask

    // pc_out = BFC00010 on entry.
    task automatic test_jump_stall();
        req_pc = 32'h8000_0000; j_valid = 1'b1; j_index = 26'h000_0040;
        sb.push_back('{32'hBFC0_0014, 1'b0});
        tick();
        clear_reqs();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jr_valid  = (i == 1);   // must be ignored while stalled
            jr_target = 32'h0000_5000;
            sb.push_back('{32'hBFC0_0014, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                jr_valid = (i == 2);
                tick();
            end
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL jump_stall_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
        stall = 1'b0;
        clear_reqs();
        sb.push_back('{32'h8000_0100, 1'b1});
        sb.push_back('{32'h8000_0104, 1'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL jump_apply_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
        checks++;
        if (redir_err !== 1'b0) begin
            errors++;
            $display("FAIL jump_err: redir_err=%b, want 0", redir_err);
        end
    endtask

    // pc_out = 80000104 on entry.
    task automatic test_fault();
        req_pc = 32'h8000_0104; jr_valid = 1'b1; jr_target = 32'h0000_1003;
        j_valid = 1'b1; j_index = 26'h000_0123;
        sb.push_back('{32'h8000_0108, 1'b0});
        tick();
        clear_reqs();
        e = sb.pop_front();
        checks++;
        if (pc_out !== e.pc || redir !== e.redir || redir_err !== 1'b1) begin
            errors++;
            $display("FAIL fault_accept: pc_out=%h redir=%b err=%b, want %h %b 1", pc_out, redir, redir_err, e.pc, e.redir);
        end
        // A branch arriving while the redirect is pending is dropped.
        req_pc = 32'h0; br_valid = 1'b1; br_taken = 1'b1; br_offset = 16'h0010;
        sb.push_back('{32'h0000_1000, 1'b1});
        tick();
        clear_reqs();
        sb.push_back('{32'h0000_1004, 1'b0});
        sb.push_back('{32'h0000_1008, 1'b0});
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir || redir_err !== 1'b1) begin
                errors++;
                $display("FAIL fault_%0d: pc_out=%h redir=%b err=%b, want %h %b 1", i, pc_out, redir, redir_err, e.pc, e.redir);
            end
        end
    endtask

    // pc_out = 00001008 on entry.
    task automatic test_wrap();
        jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
        sb.push_back('{32'h0000_100C, 1'b0});
        tick();
        clear_reqs();
        sb.push_back('{32'hFFFF_FFFC, 1'b1});
        sb.push_back('{32'h0000_0000, 1'b0});
        sb.push_back('{32'h0000_0004, 1'b0});
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL wrap_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
        checks++;
        if (redir_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: redir_err=%b, want 1", redir_err);
        end
    endtask

    // pc_out = 00000004 on entry.
    task automatic test_rst_in_pend();
        req_pc = 32'h0; j_valid = 1'b1; j_index = 26'h000_0100;
        tick();
        clear_reqs();
        checks++;
        if (pc_out !== 32'h0000_0008) begin
            errors++;
            $display("FAIL pend_accept: pc_out=%h, want 00000008", pc_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (pc_out !== 32'hBFC0_0000 || redir !== 1'b0 || redir_err !== 1'b0) begin
            errors++;
            $display("FAIL pend_reset: pc_out=%h redir=%b err=%b, want BFC00000 0 0", pc_out, redir, redir_err);
        end
        sb.push_back('{32'hBFC0_0004, 1'b0});
        sb.push_back('{32'hBFC0_0008, 1'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (pc_out !== e.pc || redir !== e.redir) begin
                errors++;
                $display("FAIL pend_discard_%0d: pc_out=%h redir=%b, want %h %b", i, pc_out, redir, e.pc, e.redir);
            end
        end
    endtask

    // Five linking jumps then five returns; stack starts empty after reset.
    task automatic test_ras();
        logic [W-1:0] push_top [5];
        logic [W-1:0] pop_top  [5];
        logic         pop_empty[5];
        push_top  = '{32'h08, 32'h18, 32'h28, 32'h38, 32'h48};
        pop_top   = '{32'h38, 32'h28, 32'h18, 32'h00, 32'h00};
        pop_empty = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                req_pc = 32'(16*i); j_valid = 1'b1; link = 1'b1; j_index = 26'h000_1000;
`ifdef PC_RAS_EN
                rsb.push_back('{push_top[i], 1'b0});
`else
                rsb.push_back('{32'h0, 1'b1});
`endif
            end else begin
                req_pc = 32'h100; jr_valid = 1'b1; link = 1'b0; jr_target = 32'h0000_2000;
`ifdef PC_RAS_EN
                rsb.push_back('{pop_top[i-5], pop_empty[i-5]});
`else
                rsb.push_back('{32'h0, 1'b1});
`endif
            end
            tick();
            clear_reqs();
            tick();
            re = rsb.pop_front();
            checks++;
            if (ras_top !== re.top || ras_empty !== re.empty) begin
                errors++;
                $display("FAIL ras_%0d: ras_top=%h empty=%b, want %h %b", i, ras_top, ras_empty, re.top, re.empty);
            end
        end
        checks++;
        if (redir_err !== 1'b0) begin
            errors++;
            $display("FAIL ras_err: redir_err=%b, want 0", redir_err);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_not_taken();
        test_jump_stall();
        test_fault();
        test_wrap();
        test_rst_in_pend();
        test_ras();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the core's next-PC adder.
- Owns the fetch PC register and sequential increment.
- Computes branch, jump and jump-register targets in a registered stage, then applies them one cycle later through a two-state redirect machine.
- Sits between decode (request source) and instruction fetch (consumer of pc_out).

Parameters:
- WIDTH, 32, address width; legal values are 28 and above. Upper bits above 28 come from the PC.
- RESET_VECTOR, 32'hBFC0_0000 (zero-extended to WIDTH), PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16. Used only with PC_RAS_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC and state; requests ignored while high
- req_pc  in  WIDTH  address of the requesting control instruction
- br_valid  in  1  conditional-branch request
- br_taken  in  1  branch condition result; qualifies br_valid
- br_offset  in  16  signed word offset
- j_valid  in  1  J/JAL request
- j_index  in  26  jump index
- jr_valid  in  1  JR/JALR request
- jr_target  in  WIDTH  register target
- link  in  1  JAL/JALR; qualifies j_valid or jr_valid
- pc_out  out  WIDTH  current fetch PC (registered)
- redir  out  1  one-cycle pulse: pc_out was just loaded from a target
- redir_err  out  1  sticky protocol-error flag
- ras_top  out  WIDTH  predicted return address (PC_RAS_EN)
- ras_empty  out  1  stack empty (PC_RAS_EN)

Behaviour:
- Reset:
  - pc_out=RESET_VECTOR, state=SEQ, latched target=0, redir=0, redir_err=0.
  - With PC_RAS_EN: RAS pointer=0, ras_empty=1, ras_top=0.
- stall=1: all registers hold; redir forced 0 on that cycle; no request is sampled.
- Target arithmetic (WIDTH-bit, modulo 2^WIDTH, carry discarded):
  - p4 = req_pc+4.
  - Branch target = p4 + (sign-extended br_offset << 2).
  - Jump target = {p4[WIDTH-1:28], j_index, 2'b00}.
  - JR target = jr_target, with bits [1:0] forced to 0.
- Request accepted = not stalled, state SEQ, and (br_valid&br_taken | j_valid | jr_valid).
  - A not-taken branch (br_valid=1, br_taken=0) is not a request.
- Priority when several are valid: jr > j > br. The winner is used and redir_err is set.
- States:
  - SEQ: each non-stalled edge does pc_out<=pc_out+4. On accept, the target is latched into a register and state goes to PEND. pc_out still advances by 4 on that edge (delay slot).
  - PEND: the next non-stalled edge does pc_out<=latched target, redir<=1, state<=SEQ. Any request seen in PEND is ignored and sets redir_err.
- Redirect latency: exactly 2 non-stalled edges from acceptance to pc_out=target. Stall cycles in PEND extend the wait and keep the target.
- pc_out wraps modulo 2^WIDTH (all-ones-minus-3 +4 gives 0). Not an error.
- rst in PEND discards the pending target; the next cycle is the reset state.
- redir_err clears only on rst.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS of RAS_DEPTH entries.
  - Accepted link request pushes req_pc+8.
  - Accepted jr_valid with link=0 pops.
  - ras_top = top entry.
  - Push when full overwrites the oldest entry (circular, the count saturates at RAS_DEPTH).
  - Pop when empty: no change, ras_empty stays 1.
  - Push and pop never occur together: JALR (jr_valid&link) is a push only.
- Undefined: no stack registers; ras_top=0 and ras_empty=1 constantly.
- Redirect behaviour is identical in both builds.

Test Plan:
- rst=1 for 2 cycles, then release with no requests → pc_out sequence BFC00000, BFC00004, BFC00008; redir=0; redir_err=0.
- At pc_out=BFC00010, request req_pc=BFC0000C, br_valid=1, br_taken=1, br_offset=16'hFFFC:
  - Next edge: pc_out=BFC00014.
  - Following edge: pc_out=BFC00000 with redir=1.
- Not-taken branch (br_taken=0) → pc_out continues +4; state stays SEQ.
- j_valid with req_pc=8000_0000, j_index=26'h0000040, stall=1 for 3 cycles after acceptance:
  - pc_out holds during the stall.
  - pc_out becomes 8000_0100 on the second non-stalled edge.
- Faults: jr_valid (jr_target=0000_1003) and j_valid together → pc_out becomes 0000_1000 after 2 edges and redir_err=1. A second request issued in PEND is ignored; redir_err stays 1 until rst.
- PC_RAS_EN, RAS_DEPTH=4:
  - 5 JAL pushes (req_pc 0,10,20,30,40) → ras_top=48.
  - 4 JR pops → ras_empty=1.
  - 5th pop → ras_top=0 and no underflow.
